// File: rtl/data_sram_responder.sv
// data_sram_responder: responder for the CPU data SRAM port (byte-writable RAM plus LED/SWITCH/TIMER window).
// Latency: read data registered, valid one cycle after the request; writes return the old word (read-first).
// Backpressure: none, a new request is accepted every cycle.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   data_sram_en          request valid this cycle
//   data_sram_wen[3:0]    byte-lane write enables (zero = read)
//   data_sram_addr[31:0]  byte address, bits [1:0] ignored
//   data_sram_wdata[31:0] write data
//   data_sram_rdata[31:0] registered read data
//   led[15:0]             LED register
//   switch[7:0]           board switches, sampled on read
// Build option: define RESPONDER_TIMER_EN to implement the free-running TIMER at offset 0xe000;
// without it that offset behaves as unmapped.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [15:0] r_led;
  logic [31:0] r_rdata;

  logic                  w_is_periph;
  logic [15:0]           w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_wr;
  logic                  w_ram_we;
  logic                  w_led_we;
  logic [31:0]           w_periph_rdata;

  // Merge new bytes into an old word under a per-lane enable mask.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign w_is_periph = (data_sram_addr[31:16] == 16'hbfaf);
  assign w_off       = data_sram_addr[15:0];
  // Upper address bits are not decoded for RAM, so accesses alias.
  assign w_idx       = data_sram_addr[ADDR_WIDTH+1:2];
  assign w_wr        = data_sram_en && (data_sram_wen != 4'b0000);
  assign w_ram_we    = w_wr && !w_is_periph;
  assign w_led_we    = w_wr && w_is_periph && (w_off == 16'hf000);

`ifdef RESPONDER_TIMER_EN
  logic [31:0] r_timer;
  logic        w_timer_we;

  assign w_timer_we = w_wr && w_is_periph && (w_off == 16'he000);

  // A write replaces the increment for that cycle; counting resumes afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_timer_we) begin
      r_timer <= lane_merge(r_timer, data_sram_wdata, data_sram_wen);
    end else begin
      r_timer <= r_timer + 32'd1;
    end
  end
`endif

  always_comb begin
    w_periph_rdata = '0;
    case (w_off)
      16'hf000: w_periph_rdata = {16'b0, r_led};
      16'hf004: w_periph_rdata = {24'b0, switch};
`ifdef RESPONDER_TIMER_EN
      16'he000: w_periph_rdata = r_timer;
`endif
      default: w_periph_rdata = '0;
    endcase
  end

  // RAM array has no reset so its contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Only the low two lanes reach the 16-bit LED register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= '0;
    end else if (w_led_we) begin
      r_led <= lane_merge({16'b0, r_led}, data_sram_wdata, {2'b00, data_sram_wen[1:0]})[15:0];
    end
  end

  // Read data samples state before the edge, giving read-first behaviour on writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (data_sram_en) begin
      r_rdata <= w_is_periph ? w_periph_rdata : r_mem[w_idx];
    end
  end

  assign data_sram_rdata = r_rdata;
  assign led             = r_led;

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;
`ifdef RESPONDER_TIMER_EN
  localparam bit TMR_EN = 1'b1;
`else
  localparam bit TMR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  sw = 8'h00;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] ram_m [int];
  logic [31:0] exp_rdata = 32'h0;
  logic [15:0] exp_led = 16'h0;
  logic [31:0] t_base = 32'h0;   // timer value at model cycle t_cyc
  int          t_cyc = 0;
  int          cyc = 0;

  data_sram_responder #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .switch          (sw)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Timer holds base + elapsed edges since it was last loaded.
  function automatic logic [31:0] timer_now();
    if (!TMR_EN) return 32'h0;
    return t_base + 32'(cyc - t_cyc);
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:16] == 16'hbfaf) begin
      if (a[15:0] == 16'hf000) return {16'h0, exp_led};
      if (a[15:0] == 16'hf004) return {24'h0, sw};
      if (a[15:0] == 16'he000) return timer_now();
      return 32'h0;
    end
    if (ram_m.exists(ram_index(a))) return ram_m[ram_index(a)];
    return 32'hxxxxxxxx;
  endfunction

  // One request cycle: inputs driven 1 time unit after a rising edge, model updated after the next edge.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rv;
    logic [31:0] told;
    en = e; wen = w; addr = a; wdata = d;
    rv   = model_read(a);
    told = timer_now();
    @(posedge clk);
    cyc++;
    #1;
    if (e) begin
      exp_rdata = rv;
      if (w != 4'h0) begin
        if (a[31:16] == 16'hbfaf) begin
          if (a[15:0] == 16'hf000) exp_led = merge({16'h0, exp_led}, d, {2'b00, w[1:0]})[15:0];
          if (a[15:0] == 16'he000 && TMR_EN) begin
            t_base = merge(told, d, w);
            t_cyc  = cyc;
          end
        end else begin
          ram_m[ram_index(a)] = merge(ram_m.exists(ram_index(a)) ? ram_m[ram_index(a)] : 32'hxxxxxxxx, d, w);
        end
      end
    end
    en = 1'b0; wen = 4'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++;
    if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
    #2 reset = 1'b0;
    t_base = 32'h0; t_cyc = cyc;
  endtask

  task automatic test_ram_full();
    step(1'b1, 4'hf, 32'h0000_0100, 32'h1234_5678);
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checks++;
    if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL ram_full got=%h exp=%h", rdata, 32'h12345678); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL idle_hold got=%h exp=%h", rdata, 32'h12345678); end
  endtask

  task automatic test_byte_lanes();
    step(1'b1, 4'b0101, 32'h0000_0100, 32'hAABB_CCDD);
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checks++;
    if (rdata !== 32'h12BB_56DD) begin failures++; $display("FAIL byte_lanes got=%h exp=%h", rdata, 32'h12BB56DD); end
  endtask

  task automatic test_read_first();
    step(1'b1, 4'hf, 32'h0000_0100, 32'hFFFF_FFFF);
    checks++;
    if (rdata !== 32'h12BB_56DD) begin failures++; $display("FAIL read_first got=%h exp=%h", rdata, 32'h12BB56DD); end
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checks++;
    if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL after_write got=%h exp=%h", rdata, 32'hFFFFFFFF); end
  endtask

  task automatic test_led_switch();
    step(1'b1, 4'hf, 32'hbfaf_f000, 32'hdead_beef);
    checks++;
    if (led !== 16'hbeef) begin failures++; $display("FAIL led_write got=%h exp=%h", led, 16'hbeef); end
    step(1'b1, 4'h0, 32'hbfaf_f000, 32'h0);
    checks++;
    if (rdata !== 32'h0000_beef) begin failures++; $display("FAIL led_read got=%h exp=%h", rdata, 32'h0000beef); end
    // Upper lanes only: LED must not change
    step(1'b1, 4'b1100, 32'hbfaf_f000, 32'h1111_2222);
    checks++;
    if (led !== 16'hbeef) begin failures++; $display("FAIL led_upper_lanes got=%h exp=%h", led, 16'hbeef); end
    sw = 8'h5a;
    step(1'b1, 4'hf, 32'hbfaf_f004, 32'hffff_ffff);
    step(1'b1, 4'h0, 32'hbfaf_f004, 32'h0);
    checks++;
    if (rdata !== 32'h0000_005a) begin failures++; $display("FAIL switch_read got=%h exp=%h", rdata, 32'h5a); end
    step(1'b1, 4'hf, 32'hbfaf_1234, 32'h5555_5555);
    step(1'b1, 4'h0, 32'hbfaf_1234, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_timer();
    logic [31:0] e1, e3;
    e1 = TMR_EN ? 32'hffff_fffe : 32'h0;
    e3 = 32'h0;
    step(1'b1, 4'hf, 32'hbfaf_e000, 32'hffff_fffe);
    step(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    checks++;
    if (rdata !== e1) begin failures++; $display("FAIL timer_load got=%h exp=%h", rdata, e1); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    checks++;
    if (rdata !== e3) begin failures++; $display("FAIL timer_wrap got=%h exp=%h", rdata, e3); end
    step(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    checks++;
    if (rdata !== exp_rdata) begin failures++; $display("FAIL timer_count got=%h exp=%h", rdata, exp_rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [15:0] hi;
    logic [15:0] offs [4];
    offs[0] = 16'hf000; offs[1] = 16'hf004; offs[2] = 16'he000; offs[3] = 16'h0000;
    // Seed a small word set with full writes so every later RAM read is defined
    for (int k = 1; k <= 8; k++) step(1'b1, 4'hf, {18'h0, 12'(k), 2'b00}, $urandom);
    for (int n = 0; n < 300; n++) begin
      sw = 8'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        do hi = 16'($urandom); while (hi == 16'hbfaf);
        a = {hi, 2'($urandom), 12'($urandom_range(1, 8)), 2'($urandom)};
      end else begin
        offs[3] = 16'($urandom);
        a = {16'hbfaf, offs[$urandom_range(0, 3)]};
      end
      step($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, a, $urandom);
      checks++;
      if (rdata !== exp_rdata) begin failures++; $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, a, rdata, exp_rdata); end
      checks++;
      if (led !== exp_led) begin failures++; $display("FAIL rand_led n=%0d got=%h exp=%h", n, led, exp_led); end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'h3, 32'hbfaf_f000, 32'h0000_beef);
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checks++;
    if (rdata !== 32'hFFFF_FFFF || led !== 16'hbeef) begin
      failures++; $display("FAIL pre_reset rdata=%h led=%h exp=%h/%h", rdata, led, 32'hFFFFFFFF, 16'hbeef);
    end
    en = 1'b1; addr = 32'h0000_0100;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL async_rst_rdata got=%h exp=%h", rdata, 32'h0); end
    checks++;
    if (led !== 16'h0) begin failures++; $display("FAIL async_rst_led got=%h exp=%h", led, 16'h0); end
    exp_rdata = 32'h0; exp_led = 16'h0;
    en = 1'b0;
    @(posedge clk); cyc++;
    #3 reset = 1'b0;
    t_base = 32'h0; t_cyc = cyc;
    step(1'b1, 4'h0, 32'hbfaf_e000, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL rst_timer got=%h exp=%h", rdata, 32'h0); end
    step(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checks++;
    if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ram_keep got=%h exp=%h", rdata, 32'hFFFFFFFF); end
  endtask

  initial begin
    test_reset();
    test_ram_full();
    test_byte_lanes();
    test_read_first();
    test_led_switch();
    test_timer();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
